// File: rtl/serial_fa_adder.sv
// Multi-cycle adder: one BITS_PER_CYCLE-wide full-adder slice plus a carry FF, reused LSB chunk first.
// Optional subtract mode is enabled by defining SERIAL_FA_ADDER_SUB_EN.

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (p & ci);
endmodule

module serial_fa_adder #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_FA_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                          state, state_next;
    logic [WIDTH-1:0]                a_q, b_q;
    logic                            carry_q;
    logic [CW-1:0]                   cnt_q;
    logic                            accept;
    logic                            last;
    logic [BITS_PER_CYCLE:0]         c;
    logic [BITS_PER_CYCLE-1:0]       chunk;
    logic [WIDTH+BITS_PER_CYCLE-1:0] sum_shift;
    logic [WIDTH-1:0]                b_init;
    logic                            carry_init;

`ifdef SERIAL_FA_ADDER_SUB_EN
    // Subtraction as a + ~b + 1; cin has no meaning in this mode.
    assign b_init     = sub ? ~b : b;
    assign carry_init = sub ? 1'b1 : cin;
`else
    assign b_init     = b;
    assign carry_init = cin;
`endif

    assign c[0] = carry_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_slice
        fa_cell u_fa (
            .a  (a_q[i]),
            .b  (b_q[i]),
            .ci (c[i]),
            .s  (chunk[i]),
            .co (c[i+1])
        );
    end

    // New chunk enters at the MSB end; after N shifts chunk 0 lands at sum[0].
    assign sum_shift = {chunk, sum};
    assign last      = (state == RUN) && (cnt_q == CW'(N - 1));

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_q     <= a;
                b_q     <= b_init;
                carry_q <= carry_init;
                cnt_q   <= '0;
            end else if (state == RUN) begin
                a_q     <= a_q >> BITS_PER_CYCLE;
                b_q     <= b_q >> BITS_PER_CYCLE;
                carry_q <= c[BITS_PER_CYCLE];
                cnt_q   <= cnt_q + 1'b1;
                sum     <= sum_shift[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
                if (last) begin
                    cout     <= c[BITS_PER_CYCLE];
                    overflow <= c[BITS_PER_CYCLE] ^ c[BITS_PER_CYCLE-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_fa_adder.sv
// Self-checking bench for serial_fa_adder: three configurations against an arithmetic reference model.
// Subtract-mode steps are included when SERIAL_FA_ADDER_SUB_EN is defined.

module tb_serial_fa_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a_in, b_in;
    logic        cin_in;
`ifdef SERIAL_FA_ADDER_SUB_EN
    logic        sub_in;
`endif
    logic [2:0]  start_v, ready_v, busy_v, done_v, cout_v, ovf_v;
    logic [7:0]  sum0, sum2;
    logic [15:0] sum1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_fa_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_d0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in),
`ifdef SERIAL_FA_ADDER_SUB_EN
        .sub(sub_in),
`endif
        .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]), .sum(sum0),
        .cout(cout_v[0]), .overflow(ovf_v[0])
    );

    serial_fa_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_d1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_in), .b(b_in), .cin(cin_in),
`ifdef SERIAL_FA_ADDER_SUB_EN
        .sub(sub_in),
`endif
        .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]), .sum(sum1),
        .cout(cout_v[1]), .overflow(ovf_v[1])
    );

    serial_fa_adder #(.WIDTH(8), .BITS_PER_CYCLE(2)) u_d2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in),
`ifdef SERIAL_FA_ADDER_SUB_EN
        .sub(sub_in),
`endif
        .ready(ready_v[2]), .busy(busy_v[2]), .done(done_v[2]), .sum(sum2),
        .cout(cout_v[2]), .overflow(ovf_v[2])
    );

    function automatic int width_of(input int k);
        return (k == 1) ? 16 : 8;
    endfunction

    function automatic int n_of(input int k);
        return (k == 0) ? 8 : 4;
    endfunction

    function automatic logic [15:0] sum_of(input int k);
        case (k)
            0:       return {8'h00, sum0};
            1:       return sum1;
            default: return {8'h00, sum2};
        endcase
    endfunction

    // Reference: plain integer arithmetic; subtraction as a + ~b + 1.
    function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic sub,
                                  output logic [15:0] s, output logic co, output logic ov);
        int unsigned mask, av, bv, tot;
        mask = (32'd1 << w) - 32'd1;
        av   = 32'(a) & mask;
        bv   = 32'(b);
        if (sub) bv = ~bv;
        bv   = bv & mask;
        tot  = av + bv + (sub ? 32'd1 : 32'(cin));
        s    = 16'(tot & mask);
        co   = tot[w];
        ov   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Latency counted in cycles after the one where start is driven.
    task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input string tag);
        logic [15:0] es;
        logic        ec, eo;
        int          lat;
        model(width_of(k), a, b, cin, sub, es, ec, eo);
        @(negedge clk);
        a_in = a; b_in = b; cin_in = cin;
`ifdef SERIAL_FA_ADDER_SUB_EN
        sub_in = sub;
`endif
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        a_in = 16'($urandom); b_in = 16'($urandom); cin_in = ~cin;
        lat = 1;
        while (!done_v[k] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(n_of(k) + 1));
        check({tag, "_sum"}, 32'(sum_of(k)), 32'(es));
        check({tag, "_cout"}, 32'(cout_v[k]), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf_v[k]), 32'(eo));
        @(negedge clk);
        check({tag, "_done_drop"}, 32'({done_v[k], ready_v[k]}), 32'b01);
    endtask

    initial begin
        int   lat;
        logic seen;
        logic [15:0] es;
        logic        ec, eo;

        rst = 1'b1; start_v = '0; a_in = '0; b_in = '0; cin_in = 1'b0;
`ifdef SERIAL_FA_ADDER_SUB_EN
        sub_in = 1'b0;
`endif
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_ready", 32'(ready_v[k]), 32'd1);
            check("rst_flags", 32'({busy_v[k], done_v[k], cout_v[k], ovf_v[k]}), 32'd0);
            check("rst_sum", 32'(sum_of(k)), 32'd0);
        end
        rst = 1'b0;

        run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, "ff_plus_1");
        run_op(0, 16'h007F, 16'h0001, 1'b0, 1'b0, "7f_plus_1");
        run_op(0, 16'h0080, 16'h0080, 1'b1, 1'b0, "80_plus_80_c");

        // Start pulsed mid-RUN with a different operand must be ignored.
        model(16, 16'h1234, 16'h0FCC, 1'b1, 1'b0, es, ec, eo);
        @(negedge clk);
        a_in = 16'h1234; b_in = 16'h0FCC; cin_in = 1'b1; start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        @(negedge clk);
        a_in = 16'hFFFF; start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        lat = 3;
        while (!done_v[1] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("ign_latency", 32'(lat), 32'd5);
        check("ign_sum", 32'(sum1), 32'h2201);
        check("ign_sum_model", 32'(sum1), 32'(es));
        check("ign_cout", 32'(cout_v[1]), 32'd0);
        check("ign_ovf", 32'(ovf_v[1]), 32'(eo));
        @(negedge clk);
        check("ign_idle", 32'({ready_v[1], busy_v[1], done_v[1]}), 32'b100);

        // Back-to-back with start held high.
        @(negedge clk);
        a_in = 16'h0010; b_in = 16'h0020; cin_in = 1'b0; start_v[2] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check("b2b_ready", 32'(ready_v[2]), 32'(i == 5 || i == 10));
            check("b2b_done", 32'(done_v[2]), 32'(i == 5 || i == 10));
            if (i == 5) begin
                check("b2b_sum1", 32'(sum2), 32'h30);
                check("b2b_cout1", 32'(cout_v[2]), 32'd0);
                a_in = 16'h00F0;
            end
            if (i == 10) begin
                check("b2b_sum2", 32'(sum2), 32'h10);
                check("b2b_cout2", 32'(cout_v[2]), 32'd1);
                start_v[2] = 1'b0;
            end
        end

        // Reset during the third RUN cycle aborts without a done pulse.
        @(negedge clk);
        a_in = 16'h00FF; b_in = 16'h00FF; cin_in = 1'b1; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 32'({ready_v[0], busy_v[0], done_v[0]}), 32'b100);
        check("abort_sum", 32'(sum0), 32'd0);
        check("abort_cout", 32'(cout_v[0]), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen = seen | done_v[0];
        end
        check("abort_no_done", 32'(seen), 32'd0);
        run_op(0, 16'h005A, 16'h00C3, 1'b1, 1'b0, "after_abort");

`ifdef SERIAL_FA_ADDER_SUB_EN
        run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, "sub_5_7");
        run_op(0, 16'h0080, 16'h0001, 1'b1, 1'b1, "sub_80_1");
        run_op(1, 16'h1000, 16'h1000, 1'b0, 1'b1, "sub_eq16");
`endif

        for (int it = 0; it < 30; it++) begin
            logic sub_r;
`ifdef SERIAL_FA_ADDER_SUB_EN
            sub_r = 1'($urandom);
`else
            sub_r = 1'b0;
`endif
            run_op(it % 3, 16'($urandom), 16'($urandom), 1'($urandom), sub_r, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_fa_adder.md
Name: serial_fa_adder

Overview:
- Parametrised multi-cycle adder: one full-adder slice of BITS_PER_CYCLE bits plus a carry flip-flop, reused over WIDTH/BITS_PER_CYCLE cycles.
- Adds operands LSB-chunk first, trading latency for area.
- Used where wide additions are infrequent and gate count matters.
- Start/done handshake to a controlling FSM.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 2.
BITS_PER_CYCLE, 1, bits processed per cycle; must divide WIDTH exactly.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only when ready=1
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start
ready  output  1  block can accept start this cycle
busy  output  1  addition in progress
done  output  1  one-cycle pulse: sum/cout/overflow valid
sum  output  WIDTH  result, held until the next accepted start
cout  output  1  carry-out of bit WIDTH-1
overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset: every output is 0 except ready=1.
  - State goes to IDLE; operand registers, carry FF and chunk counter are cleared.
  - Reset mid-operation aborts the operation; no done pulse is issued.
- Derived constant: N = WIDTH/BITS_PER_CYCLE.
- States:
  - IDLE: ready=1, busy=0.
  - RUN: ready=0, busy=1.
  - DONE: ready=1, busy=0, done=1.
- IDLE + start=1 -> RUN.
  - Captures a, b and cin into shift registers and the carry FF.
  - Chunk counter := 0.
- RUN, each cycle:
  - The slice adds the low BITS_PER_CYCLE bits of A and B plus the carry FF.
  - The result chunk shifts into sum from the MSB end, so after N shifts bit 0 is at sum[0].
  - A and B shift right by BITS_PER_CYCLE; carry FF := slice carry-out; counter increments.
- RUN, counter = N-1 -> DONE next cycle.
  - The final carry goes to cout.
  - overflow is computed from the MSB slice carries.
- DONE lasts exactly one cycle.
  - start=1 in DONE is accepted: operands are captured and the state goes to RUN (back-to-back operation).
  - Otherwise the state goes to IDLE.
- Latency: done asserts exactly N+1 cycles after the clock edge that accepted start. Throughput: one addition per N+1 cycles.
- sum, cout and overflow:
  - Change only during RUN; intermediate values are not valid.
  - Stable from DONE until the next accepted start.
- start is ignored in RUN, with no effect on the state or operands.
- Changes on a, b or cin after capture have no effect.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned. Wrap-around is visible only through cout and overflow.
- The slice is built from the team's gate-level full-adder cell chained BITS_PER_CYCLE wide. There is no behavioural "+" on the datapath.

Optional Feature:
- Macro: SERIAL_FA_ADDER_SUB_EN.
- Defined: adds the input port sub (1 bit), captured on accepted start.
  - sub=1: operand B is stored inverted and the carry FF is initialised to 1, giving sum = a - b; cin is ignored.
  - In subtract mode, cout=1 means no borrow (a >= b unsigned); overflow is signed overflow of a-b.
  - sub=0: identical to the add-only block.
- Undefined: no sub port; add only; netlist identical to the base design.

Test Plan:
- WIDTH=8, BPC=1: a=0xFF, b=0x01, cin=0 -> done at 9th cycle after start; sum=0x00, cout=1, overflow=0.
- WIDTH=8, BPC=1: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, overflow=1. Then a=0x80, b=0x80, cin=1 -> sum=0x01, cout=1, overflow=1.
- WIDTH=16, BPC=4: a=0x1234, b=0x0FCC, cin=1 -> done 5 cycles after start; sum=0x2201, cout=0.
  - Pulse start during RUN with a=0xFFFF -> ignored, result unchanged.
- Back-to-back (WIDTH=8, BPC=2): start held high -> done every 5 cycles, ready=1 only in the DONE cycles.
  - First result 0x10+0x20=0x30, second result 0xF0+0x20=0x10 with cout=1.
- Assert rst for 1 cycle at the 3rd RUN cycle -> no done pulse; next cycle ready=1, sum=0, cout=0; the next addition is correct.
- SUB_EN, WIDTH=8: sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0. Then a=0x80, b=0x01 -> sum=0x7F, cout=1, overflow=1.
